// File: rtl/snake_pkg.sv
// snake_pkg: direction encoding and helpers shared by the direction controller
// and the snake movement engine.
//   DIR_W        direction width
//   dir_t        2-bit heading, UP=0 RIGHT=1 DOWN=2 LEFT=3
//   ctrl_state_t IDLE/RUN state of the direction controller
//   opposite_dir returns the 180-degree reverse of a heading
package snake_pkg;

    localparam int unsigned DIR_W = 2;

    typedef logic [DIR_W-1:0] dir_t;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_RIGHT = 2'd1;
    localparam dir_t DIR_DOWN  = 2'd2;
    localparam dir_t DIR_LEFT  = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_t;

    // Flipping bit 1 of the encoding reverses the heading
    function automatic dir_t opposite_dir(input dir_t d);
        return d ^ DIR_W'(2);
    endfunction

endpackage

// File: rtl/snake_direction_ctrl_if.sv
// snake_direction_ctrl_if: button/tick/clear inputs and heading outputs of the
// direction controller.
//   master: drives buttons, tick, clear; observes heading, pulse, running, count
//   slave : the controller side
interface snake_direction_ctrl_if #(
    parameter int unsigned COUNT_W = 2
);
    import snake_pkg::*;

    logic               in_btn_up;
    logic               in_btn_right;
    logic               in_btn_down;
    logic               in_btn_left;
    logic               in_game_tick;
    logic               in_clear;
    dir_t               out_direction;
    logic               out_dir_changed;
    logic               out_running;
    logic [COUNT_W-1:0] out_queue_count;

    modport master (
        output in_btn_up, in_btn_right, in_btn_down, in_btn_left,
        output in_game_tick, in_clear,
        input  out_direction, out_dir_changed, out_running, out_queue_count
    );

    modport slave (
        input  in_btn_up, in_btn_right, in_btn_down, in_btn_left,
        input  in_game_tick, in_clear,
        output out_direction, out_dir_changed, out_running, out_queue_count
    );

endinterface

// File: rtl/direction_fifo.sv
// direction_fifo: synchronous DEPTH x 2-bit queue of pending turn requests.
//   clk, rst_n  clock, async active-low reset
//   flush       drop all entries
//   push/wr_data enqueue (taken when not full, or full with a same-cycle pop)
//   pop/rd_data_c dequeue head (head shown combinationally)
//   full_c/empty_c status, count registered occupancy
module direction_fifo
    import snake_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned COUNT_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               push,
    input  dir_t               wr_data,
    input  logic               pop,
    output dir_t               rd_data_c,
    output logic               full_c,
    output logic               empty_c,
    output logic [COUNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    dir_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push_c;
    logic             do_pop_c;

    assign empty_c   = (count == '0);
    assign full_c    = (count == COUNT_W'(DEPTH));
    assign rd_data_c = mem[rd_ptr];

    // A same-cycle pop frees a slot for the push
    assign do_pop_c  = pop && !empty_c;
    assign do_push_c = push && (!full_c || do_pop_c);

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= DIR_RIGHT;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push_c, do_pop_c})
                2'b10:   count <= count + COUNT_W'(1);
                2'b01:   count <= count - COUNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/snake_direction_ctrl.sv
// snake_direction_ctrl: turns debounced button levels into the snake heading.
// Button rising edges become turn requests, legal ones are queued and one is
// applied per game tick; 180-degree reversals are never queued.
//   in_clock, in_reset_n  clock, async active-low reset
//   bus (slave)           buttons, tick, clear in; heading, change pulse,
//                         running flag and queue occupancy out
module snake_direction_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 2,
    parameter int unsigned COUNT_W     = 2
) (
    input  logic                 in_clock,
    input  logic                 in_reset_n,
    snake_direction_ctrl_if.slave bus
);

    logic [3:0]         btn_c;
    logic [3:0]         prev_q;
    logic [3:0]         rise_c;
    logic               req_valid_c;
    dir_t               req_c;
    logic               legal_c;
    logic               push_c;
    logic               pop_c;
    logic               full_c;
    logic               empty_c;
    dir_t               head_c;
    logic [COUNT_W-1:0] count;
    dir_t               last_dir_q;
    dir_t               direction_q;
    logic               dir_changed_q;
    ctrl_state_t        state_q;
    ctrl_state_t        state_d;

    // Bit index equals the direction code
    assign btn_c  = {bus.in_btn_left, bus.in_btn_down, bus.in_btn_right, bus.in_btn_up};
    assign rise_c = btn_c & ~prev_q;

    // One request per cycle, UP > RIGHT > DOWN > LEFT
    always_comb begin
        req_valid_c = |rise_c;
        req_c       = DIR_UP;
        if      (rise_c[DIR_UP])    req_c = DIR_UP;
        else if (rise_c[DIR_RIGHT]) req_c = DIR_RIGHT;
        else if (rise_c[DIR_DOWN])  req_c = DIR_DOWN;
        else                        req_c = DIR_LEFT;
    end

    // Legality is judged against the last accepted request, not the heading
    assign legal_c = (req_c != last_dir_q) && (req_c != opposite_dir(last_dir_q));
    assign pop_c   = bus.in_game_tick && (state_q == ST_RUN) && !empty_c && !bus.in_clear;
    assign push_c  = req_valid_c && legal_c && (!full_c || pop_c) && !bus.in_clear;

    direction_fifo #(
        .DEPTH   (QUEUE_DEPTH),
        .COUNT_W (COUNT_W)
    ) u_fifo (
        .clk       (in_clock),
        .rst_n     (in_reset_n),
        .flush     (bus.in_clear),
        .push      (push_c),
        .wr_data   (req_c),
        .pop       (pop_c),
        .rd_data_c (head_c),
        .full_c    (full_c),
        .empty_c   (empty_c),
        .count     (count)
    );

    // IDLE/RUN next state
    always_comb begin
        state_d = state_q;
        if (bus.in_clear)                          state_d = ST_IDLE;
        else if ((state_q == ST_IDLE) && push_c)   state_d = ST_RUN;
    end

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    // prev tracks the buttons even during clear so held buttons do not re-fire
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            prev_q        <= '0;
            last_dir_q    <= DIR_RIGHT;
            direction_q   <= DIR_RIGHT;
            dir_changed_q <= 1'b0;
        end else begin
            prev_q        <= btn_c;
            dir_changed_q <= pop_c;
            if (bus.in_clear) begin
                last_dir_q  <= DIR_RIGHT;
                direction_q <= DIR_RIGHT;
            end else begin
                if (push_c) last_dir_q  <= req_c;
                if (pop_c)  direction_q <= head_c;
            end
        end
    end

    assign bus.out_direction   = direction_q;
    assign bus.out_dir_changed = dir_changed_q;
    assign bus.out_running     = (state_q == ST_RUN);
    assign bus.out_queue_count = count;

endmodule

// File: tb/tb_snake_direction_ctrl.sv
// Self-checking bench for snake_direction_ctrl: a table of per-cycle
// {buttons, tick, clear, expected outputs} records plus a mid-queue reset
// sequence; expected outputs pass through a scoreboard queue.
module tb_snake_direction_ctrl;
    import snake_pkg::*;

    localparam int unsigned QUEUE_DEPTH = 2;
    localparam int unsigned COUNT_W     = 2;

    localparam logic [3:0] B_0 = 4'b0000;
    localparam logic [3:0] B_U = 4'b0001;
    localparam logic [3:0] B_D = 4'b0100;
    localparam logic [3:0] B_L = 4'b1000;

    typedef struct packed {
        logic [1:0]         dir;
        logic               chg;
        logic               run;
        logic [COUNT_W-1:0] cnt;
    } exp_t;

    typedef struct {
        logic [3:0] btn;
        logic       tick;
        logic       clear;
        exp_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    vec_t vecs[$];

    snake_direction_ctrl_if #(.COUNT_W(COUNT_W)) bus();

    snake_direction_ctrl #(
        .QUEUE_DEPTH (QUEUE_DEPTH),
        .COUNT_W     (COUNT_W)
    ) dut (
        .in_clock   (clk),
        .in_reset_n (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic vec_t mk(input logic [3:0] b, input logic t, input logic c,
                                input logic [1:0] d, input logic g, input logic r,
                                input logic [COUNT_W-1:0] n);
        vec_t v;
        v.btn     = b;
        v.tick    = t;
        v.clear   = c;
        v.exp.dir = d;
        v.exp.chg = g;
        v.exp.run = r;
        v.exp.cnt = n;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s step=%0d got=%0d want=%0d", name, idx, act, want);
        end
    endtask

    task automatic drive(input logic [3:0] b, input logic t, input logic c, input exp_t e);
        bus.in_btn_up    = b[0];
        bus.in_btn_right = b[1];
        bus.in_btn_down  = b[2];
        bus.in_btn_left  = b[3];
        bus.in_game_tick = t;
        bus.in_clear     = c;
        exp_q.push_back(e);
    endtask

    task automatic sample(input int idx);
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard step=%0d got=empty want=entry", idx);
        end else begin
            e = exp_q.pop_front();
            check("direction",   idx, 8'(bus.out_direction),   8'(e.dir));
            check("dir_changed", idx, 8'(bus.out_dir_changed), 8'(e.chg));
            check("running",     idx, 8'(bus.out_running),     8'(e.run));
            check("queue_count", idx, 8'(bus.out_queue_count), 8'(e.cnt));
        end
    endtask

    task automatic step(input int idx, input vec_t v);
        drive(v.btn, v.tick, v.clear, v.exp);
        sample(idx);
    endtask

    initial begin
        // btn, tick, clear -> direction, changed, running, count
        vecs.push_back(mk(B_0,       1, 0, 1, 0, 0, 0)); // idle ticks ignored
        vecs.push_back(mk(B_0,       1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(B_U,       0, 0, 1, 0, 1, 1)); // UP accepted
        vecs.push_back(mk(B_U,       1, 0, 0, 1, 1, 0)); // tick applies UP
        vecs.push_back(mk(B_U,       0, 0, 0, 0, 1, 0)); // held, no re-push
        vecs.push_back(mk(B_U,       1, 0, 0, 0, 1, 0)); // empty tick
        vecs.push_back(mk(B_0,       0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(B_D,       0, 0, 0, 0, 1, 0)); // reversal rejected
        vecs.push_back(mk(B_0,       0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(B_D,       0, 0, 0, 0, 1, 0)); // DOWN rejected
        vecs.push_back(mk(B_L,       0, 0, 0, 0, 1, 1)); // then LEFT accepted
        vecs.push_back(mk(B_0,       1, 0, 3, 1, 1, 0));
        vecs.push_back(mk(B_0,       0, 0, 3, 0, 1, 0));
        vecs.push_back(mk(B_0,       0, 1, 1, 0, 0, 0)); // clear
        vecs.push_back(mk(B_U,       0, 0, 1, 0, 1, 1));
        vecs.push_back(mk(B_0,       0, 0, 1, 0, 1, 1));
        vecs.push_back(mk(B_L,       0, 0, 1, 0, 1, 2)); // double turn queued
        vecs.push_back(mk(B_0,       0, 0, 1, 0, 1, 2));
        vecs.push_back(mk(B_D,       0, 0, 1, 0, 1, 2)); // full, dropped
        vecs.push_back(mk(B_0,       0, 0, 1, 0, 1, 2));
        vecs.push_back(mk(B_D,       1, 0, 0, 1, 1, 2)); // push into full with pop
        vecs.push_back(mk(B_0,       1, 0, 3, 1, 1, 1));
        vecs.push_back(mk(B_0,       1, 0, 2, 1, 1, 0));
        vecs.push_back(mk(B_0,       1, 0, 2, 0, 1, 0));
        vecs.push_back(mk(B_0,       0, 1, 1, 0, 0, 0)); // clear
        vecs.push_back(mk(B_U | B_L, 0, 0, 1, 0, 1, 1)); // only UP queued
        vecs.push_back(mk(B_0,       1, 0, 0, 1, 1, 0));
        vecs.push_back(mk(B_0,       1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(B_L,       0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(B_0,       0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(B_D,       0, 0, 0, 0, 1, 2));
        vecs.push_back(mk(B_0,       0, 1, 1, 0, 0, 0)); // clear with count=2
        vecs.push_back(mk(B_U,       0, 1, 1, 0, 0, 0)); // edge in clear dropped
        vecs.push_back(mk(B_U,       0, 0, 1, 0, 0, 0)); // held, no re-fire
        vecs.push_back(mk(B_0,       0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(B_U,       1, 0, 1, 0, 1, 1)); // tick ignored in IDLE
        vecs.push_back(mk(B_0,       1, 0, 0, 1, 1, 0));
        vecs.push_back(mk(B_L,       0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(B_0,       0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(B_D,       0, 0, 0, 0, 1, 2)); // queue now holds 2

        bus.in_btn_up    = 1'b0;
        bus.in_btn_right = 1'b0;
        bus.in_btn_down  = 1'b0;
        bus.in_btn_left  = 1'b0;
        bus.in_game_tick = 1'b0;
        bus.in_clear     = 1'b0;
        rst_n            = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_direction",   -1, 8'(bus.out_direction),   8'd1);
        check("reset_dir_changed", -1, 8'(bus.out_dir_changed), 8'd0);
        check("reset_running",     -1, 8'(bus.out_running),     8'd0);
        check("reset_queue_count", -1, 8'(bus.out_queue_count), 8'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) step(i, vecs[i]);

        // Asynchronous reset mid-queue, sampled with no clock edge in between
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_direction",   100, 8'(bus.out_direction),   8'd1);
        check("async_rst_dir_changed", 100, 8'(bus.out_dir_changed), 8'd0);
        check("async_rst_running",     100, 8'(bus.out_running),     8'd0);
        check("async_rst_queue_count", 100, 8'(bus.out_queue_count), 8'd0);
        drive(B_0, 1'b0, 1'b0, exp_t'(0));
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(101, mk(B_0, 1, 0, 1, 0, 0, 0));
        step(102, mk(B_U, 0, 0, 1, 0, 1, 1));
        step(103, mk(B_0, 1, 0, 0, 1, 1, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
